uart_cmd_auth: RTL and testbench



---
 rtl/uart_cmd_auth.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_auth.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_auth.sv
// 8N1 serial command receiver with a power authorization FSM.
// Decodes GO/STOP command bytes and combines them with rider_off to drive pwr_up.
module uart_cmd_auth #(
  parameter int unsigned BAUD_DIV = 5208,
  parameter logic [7:0]  CMD_GO   = 8'h47,
  parameter logic [7:0]  CMD_STOP = 8'h53
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       RX,
  input  logic       rider_off,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err,
  output logic       pwr_up
);

  localparam int unsigned CW = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI
  } rx_state_t;

  typedef enum logic [1:0] {
    OFF, PWR1, PWR2
  } auth_state_t;

  rx_state_t   rx_state, rx_state_nxt;
  auth_state_t auth_state, auth_nxt;

  logic          rx_s1, rx_s2, rx_d;
  logic          rx_fall, expired;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    rx_data_nxt;
  logic          rdy_nxt, err_nxt;
  logic          got_go, got_stop;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;
  assign expired = (cnt == '0);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      rx_data  <= rx_data_nxt;
      rx_rdy   <= rdy_nxt;
      frm_err  <= err_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    rx_data_nxt  = rx_data;
    rdy_nxt      = 1'b0;
    err_nxt      = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          cnt_nxt      = CNT_HALF;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (!expired) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!rx_s2) begin
          cnt_nxt      = CNT_FULL;
          bit_idx_nxt  = '0;
          rx_state_nxt = RX_DATA;
        end else begin
          rx_state_nxt = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!expired) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shreg_nxt   = {rx_s2, shreg[7:1]};
          cnt_nxt     = CNT_FULL;
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            rx_state_nxt = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (!expired) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rx_s2) begin
          rx_data_nxt  = shreg;
          rdy_nxt      = 1'b1;
          rx_state_nxt = RX_IDLE;
        end else begin
          err_nxt      = 1'b1;
          rx_state_nxt = RX_WAIT_HI;
        end
      end
      RX_WAIT_HI: begin
        if (rx_s2) begin
          rx_state_nxt = RX_IDLE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  assign got_go   = rx_rdy && (rx_data == CMD_GO);
  assign got_stop = rx_rdy && (rx_data == CMD_STOP);

  // pwr_up is registered from the next state so it tracks auth_state exactly.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      auth_state <= OFF;
      pwr_up     <= 1'b0;
    end else begin
      auth_state <= auth_nxt;
      pwr_up     <= (auth_nxt != OFF);
    end
  end

  always_comb begin
    auth_nxt = auth_state;
    unique case (auth_state)
      OFF: begin
        if (got_go) auth_nxt = PWR1;
      end
      PWR1: begin
        if (got_stop) auth_nxt = rider_off ? OFF : PWR2;
      end
      PWR2: begin
        if (rider_off)   auth_nxt = OFF;
        else if (got_go) auth_nxt = PWR1;
      end
      default: auth_nxt = OFF;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_auth.sv
// Directed bench for uart_cmd_auth: framing, glitch rejection, reset abort and auth FSM.
module tb_uart_cmd_auth;

  localparam int BAUD = 256;
  localparam int BIT  = BAUD + 1;
  localparam int NOM  = 2 + BAUD / 2 + 9 * (BAUD + 1);

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       RX = 1'b1;
  logic       rider_off = 1'b0;
  logic [7:0] rx_data;
  logic       rx_rdy, frm_err, pwr_up;

  int total = 0, bad = 0;
  int cyc = 0, fall_cyc = 0, last_rdy_cyc = 0;
  int rdy_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic pwr_at, pwr_after;
  logic cap_pending = 1'b0, prev_rdy = 1'b0, prev_err = 1'b0;
  logic watch_to = 1'b0;

  uart_cmd_auth #(.BAUD_DIV(BAUD), .CMD_GO(8'h47), .CMD_STOP(8'h53)) dut (
    .clk(clk), .RST(RST), .RX(RX), .rider_off(rider_off),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .frm_err(frm_err), .pwr_up(pwr_up)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cap_pending) begin
      pwr_after   = pwr_up;
      cap_pending = 1'b0;
    end
    if (rx_rdy === 1'b1) begin
      rdy_cnt++;
      last_rdy_cyc = cyc;
      last_data    = rx_data;
      pwr_at       = pwr_up;
      cap_pending  = 1'b1;
    end
    if (frm_err === 1'b1) err_cnt++;
    if (rx_rdy === 1'b1 && frm_err === 1'b1) both_cnt++;
    if ((rx_rdy === 1'b1 && prev_rdy) || (frm_err === 1'b1 && prev_err)) wide_cnt++;
    prev_rdy = (rx_rdy === 1'b1);
    prev_err = (frm_err === 1'b1);
  end

  task automatic clear_counts();
    rdy_cnt   = 0;
    err_cnt   = 0;
    pwr_at    = 1'bx;
    pwr_after = 1'bx;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(negedge clk);
    RX = 1'b0;
    fall_cyc = cyc + 1;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (BIT) @(negedge clk);
    end
    RX = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    total++; if (rx_rdy !== 1'b0) begin bad++; $display("FAIL reset_rx_rdy: got %b want 0", rx_rdy); end
    total++; if (frm_err !== 1'b0) begin bad++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
    total++; if (pwr_up !== 1'b0) begin bad++; $display("FAIL reset_pwr_up: got %b want 0", pwr_up); end
    RST = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_go();
    int d;
    clear_counts();
    rider_off = 1'b0;
    send_byte(8'h47, 1'b1);
    repeat (5) @(negedge clk);
    d = last_rdy_cyc - fall_cyc;
    total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL go_rdy_count: got %0d want 1", rdy_cnt); end
    total++; if (last_data !== 8'h47) begin bad++; $display("FAIL go_data: got %h want 47", last_data); end
    total++; if (d < NOM - 2 || d > NOM + 2) begin bad++; $display("FAIL go_latency: got %0d want %0d+-2", d, NOM); end
    total++; if (pwr_at !== 1'b0) begin bad++; $display("FAIL go_pwr_at_rdy: got %b want 0", pwr_at); end
    total++; if (pwr_after !== 1'b1) begin bad++; $display("FAIL go_pwr_after: got %b want 1", pwr_after); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL go_frm_err: got %0d want 0", err_cnt); end
  endtask

  task automatic test_stop_hold();
    clear_counts();
    send_byte(8'h53, 1'b1);
    repeat (5) @(negedge clk);
    total++; if (last_data !== 8'h53) begin bad++; $display("FAIL hold_data: got %h want 53", last_data); end
    total++; if (pwr_after !== 1'b1) begin bad++; $display("FAIL hold_pwr2: got %b want 1", pwr_after); end
    total++; if (pwr_up !== 1'b1) begin bad++; $display("FAIL hold_pwr_steady: got %b want 1", pwr_up); end
    rider_off = 1'b1;
    total++; if (pwr_up !== 1'b1) begin bad++; $display("FAIL hold_pwr_before_edge: got %b want 1", pwr_up); end
    @(negedge clk);
    total++; if (pwr_up !== 1'b0) begin bad++; $display("FAIL hold_pwr_fall: got %b want 0", pwr_up); end
    rider_off = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stop_off();
    clear_counts();
    send_byte(8'h47, 1'b1);
    repeat (5) @(negedge clk);
    total++; if (pwr_after !== 1'b1) begin bad++; $display("FAIL off_go_pwr: got %b want 1", pwr_after); end
    rider_off = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (pwr_up !== 1'b1) begin bad++; $display("FAIL off_pwr1_ignores_rider: got %b want 1", pwr_up); end
    clear_counts();
    send_byte(8'h53, 1'b1);
    repeat (5) @(negedge clk);
    total++; if (pwr_at !== 1'b1) begin bad++; $display("FAIL off_pwr_at_rdy: got %b want 1", pwr_at); end
    total++; if (pwr_after !== 1'b0) begin bad++; $display("FAIL off_pwr_after: got %b want 0", pwr_after); end
    rider_off = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_byte(8'h47, 1'b0);
    repeat (3 * 10 * BIT) @(negedge clk);
    RX = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", err_cnt); end
    total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL ferr_no_rdy: got %0d want 0", rdy_cnt); end
    total++; if (pwr_up !== 1'b0) begin bad++; $display("FAIL ferr_pwr: got %b want 0", pwr_up); end
    total++; if (rx_data !== 8'h53) begin bad++; $display("FAIL ferr_data_kept: got %h want 53", rx_data); end
  endtask

  task automatic test_glitch();
    clear_counts();
    @(negedge clk);
    RX = 1'b0;
    repeat (100) @(negedge clk);
    RX = 1'b1;
    repeat (300) @(negedge clk);
    total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL glitch_rdy: got %0d want 0", rdy_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", err_cnt); end
    send_byte(8'h41, 1'b1);
    repeat (5) @(negedge clk);
    total++; if (last_data !== 8'h41) begin bad++; $display("FAIL glitch_next_data: got %h want 41", last_data); end
    total++; if (pwr_after !== 1'b0) begin bad++; $display("FAIL glitch_next_pwr: got %b want 0", pwr_after); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h47;
    clear_counts();
    @(negedge clk);
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = d[i];
      repeat (BIT) @(negedge clk);
    end
    RX = d[4];
    repeat (BIT / 2) @(negedge clk);
    RST = 1'b1;
    RX  = 1'b1;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL rstmid_no_rdy: got %0d want 0", rdy_cnt); end
    send_byte(8'h47, 1'b1);
    repeat (5) @(negedge clk);
    total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL rstmid_rdy_count: got %0d want 1", rdy_cnt); end
    total++; if (pwr_up !== 1'b1) begin bad++; $display("FAIL rstmid_pwr: got %b want 1", pwr_up); end
  endtask

  task automatic test_pwr2_priority();
    clear_counts();
    send_byte(8'h53, 1'b1);
    repeat (5) @(negedge clk);
    total++; if (pwr_after !== 1'b1) begin bad++; $display("FAIL prio_enter_pwr2: got %b want 1", pwr_after); end
    clear_counts();
    fork
      send_byte(8'h47, 1'b1);
      begin : watch
        int w;
        w = 0;
        while (rx_rdy !== 1'b1 && w < 4000) begin
          @(negedge clk);
          w++;
        end
        watch_to  = (w >= 4000);
        rider_off = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    total++; if (watch_to !== 1'b0) begin bad++; $display("FAIL prio_rdy_timeout: got %b want 0", watch_to); end
    total++; if (pwr_at !== 1'b1) begin bad++; $display("FAIL prio_pwr_at_rdy: got %b want 1", pwr_at); end
    total++; if (pwr_after !== 1'b0) begin bad++; $display("FAIL prio_rider_wins: got %b want 0", pwr_after); end
    total++; if (pwr_up !== 1'b0) begin bad++; $display("FAIL prio_pwr_stays_off: got %b want 0", pwr_up); end
    rider_off = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_go();
    test_stop_hold();
    test_stop_off();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_pwr2_priority();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL rdy_err_overlap: got %0d want 0", both_cnt); end
    total++; if (wide_cnt !== 0) begin bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
